// File: rtl/phase_select_sequencer_pkg.sv
// rtl/phase_select_sequencer_pkg.sv - shared load codes, direction enum and sync depth
// Load codes match the downstream commutation FSM DesiredLoad encoding.
package phase_select_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD_NUL = 2'b00,
        LOAD_A   = 2'b01,
        LOAD_B   = 2'b10,
        LOAD_C   = 2'b11
    } load_t;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/phase_select_sequencer_current_sign_filter.sv
// rtl/phase_select_sequencer_current_sign_filter.sv - synchronised run-length filter for the output-current sign
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_pos_raw      async comparator, current above +band
//   i_neg_raw      async comparator, current below -band
//   current_sign   filtered sign, 1=positive, 0=negative
module current_sign_filter
    import phase_select_sequencer_pkg::*;
#(
    parameter int SIGN_FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pos_raw,
    input  logic i_neg_raw,
    output logic current_sign
);

    localparam int RUN_W = $clog2(SIGN_FILT + 1);

    logic [SYNC_DEPTH-1:0] pos_sync;
    logic [SYNC_DEPTH-1:0] neg_sync;
    logic [RUN_W-1:0]      run;
    logic                  pos_s;
    logic                  neg_s;
    logic                  opposing;

    assign pos_s = pos_sync[SYNC_DEPTH-1];
    assign neg_s = neg_sync[SYNC_DEPTH-1];

    // Only a clean one-sided sample that disagrees with the held sign can
    // advance the run; agreeing, zero-band or illegal samples restart it.
    assign opposing = (pos_s ^ neg_s) && (pos_s != current_sign);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_sync     <= '0;
            neg_sync     <= '0;
            run          <= '0;
            current_sign <= 1'b0;
        end else begin
            pos_sync <= {pos_sync[SYNC_DEPTH-2:0], i_pos_raw};
            neg_sync <= {neg_sync[SYNC_DEPTH-2:0], i_neg_raw};
            if (opposing) begin
                if (run == RUN_W'(SIGN_FILT - 1)) begin
                    current_sign <= pos_s;
                    run          <= '0;
                end else begin
                    run <= run + RUN_W'(1);
                end
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/phase_select_sequencer.sv
// rtl/phase_select_sequencer.sv - duty-to-phase time slicer with symmetric sequencing, sign filter and fault latch
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en                   run enable (level)
//   period, duty_a/b     per-period counts, captured at each shadow load
//   i_pos_raw/i_neg_raw  async current comparators
//   fault_in             async desat/overcurrent fault
//   desired_load         selected phase (01=A, 10=B, 11=C, 00=none)
//   current_sign         filtered current sign
//   start                commutation FSM enable
//   short_out            sticky fault, cleared only by rst
//   period_tick          pulse in the cycle following each valid shadow load
//   cfg_err              sticky config error, cleared by the next clean load
module phase_select_sequencer
    import phase_select_sequencer_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int MIN_DWELL = 4,
    parameter int SIGN_FILT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    input  logic             i_pos_raw,
    input  logic             i_neg_raw,
    input  logic             fault_in,
    output logic [1:0]       desired_load,
    output logic             current_sign,
    output logic             start,
    output logic             short_out,
    output logic             period_tick,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DWELL);

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      sh_p, sh_a, sh_b, sh_c;
    logic                  running;
    dir_t                  dir;
    logic [SYNC_DEPTH-1:0] fault_sync;
    logic                  fault_s;
    logic                  kill;
    logic                  load;

    logic                  period_ok, clamp_a, clamp_b;
    logic [CNT_W-1:0]      a_cl, b_cl, c_cl, rem;
    logic                  tr_a, tr_b, tr_c;
    logic [CNT_W-1:0]      extra;
    load_t                 rx;
    logic [CNT_W-1:0]      new_a, new_b, new_c;
    load_t                 seg;

    assign fault_s = fault_sync[SYNC_DEPTH-1];
    assign kill    = short_out | fault_s;
    // While not running every enabled cycle is a load attempt, which is what
    // makes an invalid period get re-evaluated until it becomes usable.
    assign load    = en && (!running || (cnt == sh_p - CNT_W'(1)));

    // Clamp the incoming duties into the period, then fold sub-dwell
    // segments into the largest one. The largest clamped duty is the
    // receiver; if it is itself too short, it simply absorbs the whole period.
    always_comb begin
        period_ok = (period >= MIN_D);
        clamp_a   = (duty_a > period);
        a_cl      = clamp_a ? period : duty_a;
        rem       = period - a_cl;
        clamp_b   = (duty_b > rem);
        b_cl      = clamp_b ? rem : duty_b;
        c_cl      = rem - b_cl;

        tr_a  = (a_cl != '0) && (a_cl < MIN_D);
        tr_b  = (b_cl != '0) && (b_cl < MIN_D);
        tr_c  = (c_cl != '0) && (c_cl < MIN_D);
        extra = (tr_a ? a_cl : '0) + (tr_b ? b_cl : '0) + (tr_c ? c_cl : '0);

        if (a_cl >= b_cl && a_cl >= c_cl) begin
            rx = LOAD_A;
        end else if (b_cl >= c_cl) begin
            rx = LOAD_B;
        end else begin
            rx = LOAD_C;
        end

        new_a = (tr_a ? '0 : a_cl) + ((rx == LOAD_A) ? extra : '0);
        new_b = (tr_b ? '0 : b_cl) + ((rx == LOAD_B) ? extra : '0);
        new_c = (tr_c ? '0 : c_cl) + ((rx == LOAD_C) ? extra : '0);
    end

    // Shadow duties sum to the shadow period, so the final segment needs no
    // upper-bound compare and zero-length segments fall through naturally.
    always_comb begin
        seg = LOAD_NUL;
        if (dir == FWD) begin
            if (cnt < sh_a) begin
                seg = LOAD_A;
            end else if (cnt < sh_a + sh_b) begin
                seg = LOAD_B;
            end else begin
                seg = LOAD_C;
            end
        end else begin
            if (cnt < sh_c) begin
                seg = LOAD_C;
            end else if (cnt < sh_c + sh_b) begin
                seg = LOAD_B;
            end else begin
                seg = LOAD_A;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_sync   <= '0;
            short_out    <= 1'b0;
            cnt          <= '0;
            running      <= 1'b0;
            dir          <= FWD;
            sh_p         <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            sh_c         <= '0;
            start        <= 1'b0;
            desired_load <= LOAD_NUL;
            period_tick  <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            fault_sync <= {fault_sync[SYNC_DEPTH-2:0], fault_in};
            if (fault_s) begin
                short_out <= 1'b1;
            end

            if (!en) begin
                cnt          <= '0;
                running      <= 1'b0;
                dir          <= FWD;
                start        <= 1'b0;
                desired_load <= LOAD_NUL;
                period_tick  <= 1'b0;
            end else begin
                // Outputs reflect the segment of the current count, so the
                // last slot of a period is emitted on the cycle its load edge fires.
                start        <= running && !kill;
                desired_load <= (running && !kill) ? seg : LOAD_NUL;
                if (load) begin
                    cnt         <= '0;
                    sh_p        <= period;
                    sh_a        <= new_a;
                    sh_b        <= new_b;
                    sh_c        <= new_c;
                    cfg_err     <= !period_ok || clamp_a || clamp_b;
                    running     <= period_ok;
                    period_tick <= period_ok;
                    // A fresh start is always forward; back-to-back periods alternate.
                    dir         <= running ? ((dir == FWD) ? REV : FWD) : FWD;
                end else begin
                    cnt         <= cnt + CNT_W'(1);
                    period_tick <= 1'b0;
                end
            end
        end
    end

    current_sign_filter #(
        .SIGN_FILT(SIGN_FILT)
    ) u_sign (
        .clk         (clk),
        .rst         (rst),
        .i_pos_raw   (i_pos_raw),
        .i_neg_raw   (i_neg_raw),
        .current_sign(current_sign)
    );

endmodule

// File: tb/tb_phase_select_sequencer.sv
// tb/tb_phase_select_sequencer.sv - directed self-checking bench for phase_select_sequencer
module tb_phase_select_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] period, duty_a, duty_b;
    logic        i_pos_raw, i_neg_raw, fault_in;
    logic [1:0]  desired_load;
    logic        current_sign, start, short_out, period_tick, cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_select_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period      (period),
        .duty_a      (duty_a),
        .duty_b      (duty_b),
        .i_pos_raw   (i_pos_raw),
        .i_neg_raw   (i_neg_raw),
        .fault_in    (fault_in),
        .desired_load(desired_load),
        .current_sign(current_sign),
        .start       (start),
        .short_out   (short_out),
        .period_tick (period_tick),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Period 1 forward A30 B50 C20, period 2 reverse C20 B50 A30.
    function automatic logic [1:0] t1_exp(input int i);
        int k;
        k = i % 100;
        if (i < 100) return (k < 30) ? 2'b01 : (k < 80) ? 2'b10 : 2'b11;
        else         return (k < 20) ? 2'b11 : (k < 70) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; period = '0; duty_a = '0; duty_b = '0;
        i_pos_raw = 1'b0; i_neg_raw = 1'b0; fault_in = 1'b0;
        nclk(2);
        chk("rst_load", desired_load, 2'b00);
        chk("rst_sign", current_sign, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_short", short_out, 1'b0);
        chk("rst_tick", period_tick, 1'b0);
        chk("rst_cfg", cfg_err, 1'b0);
        rst = 1'b0;
        nclk(1);

        // Symmetric sequencing
        period = 100; duty_a = 30; duty_b = 50; en = 1'b1;
        nclk(1);
        chk("t1_tick0", period_tick, 1'b1);
        chk("t1_start0", start, 1'b0);
        chk("t1_cfg", cfg_err, 1'b0);
        for (int i = 0; i < 160; i++) begin
            nclk(1);
            chk($sformatf("t1_load_%0d", i), desired_load, t1_exp(i));
            chk($sformatf("t1_start_%0d", i), start, 1'b1);
            chk($sformatf("t1_tick_%0d", i), period_tick, (i % 100 == 99) ? 1'b1 : 1'b0);
        end

        // en drop at cnt=60 of the reverse period
        en = 1'b0;
        nclk(1);
        chk("drop_load", desired_load, 2'b00);
        chk("drop_start", start, 1'b0);
        period = 40; duty_a = 10; duty_b = 10; en = 1'b1;
        nclk(1);
        chk("reen_tick", period_tick, 1'b1);
        nclk(1);
        chk("reen_load_a", desired_load, 2'b01);
        chk("reen_start", start, 1'b1);
        nclk(10);
        chk("reen_load_b", desired_load, 2'b10);

        // Invalid period, then recovery
        en = 1'b0;
        nclk(1);
        period = 3; duty_a = 1; duty_b = 1; en = 1'b1;
        nclk(3);
        chk("inv_cfg", cfg_err, 1'b1);
        chk("inv_start", start, 1'b0);
        chk("inv_load", desired_load, 2'b00);
        chk("inv_tick", period_tick, 1'b0);
        period = 50; duty_a = 25; duty_b = 25;
        nclk(1);
        chk("rec_tick", period_tick, 1'b1);
        chk("rec_cfg", cfg_err, 1'b0);
        nclk(1);
        chk("rec_start", start, 1'b1);
        chk("rec_load_a", desired_load, 2'b01);
        nclk(25);
        chk("rec_load_b", desired_load, 2'b10);

        // Trim and clamp: a=2 trimmed, b clamped to 98 then absorbs a -> B all period
        en = 1'b0;
        nclk(1);
        period = 100; duty_a = 2; duty_b = 120; en = 1'b1;
        nclk(1);
        chk("tc_cfg", cfg_err, 1'b1);
        chk("tc_tick", period_tick, 1'b1);
        for (int i = 0; i < 110; i++) begin
            nclk(1);
            chk($sformatf("tc_load_%0d", i), desired_load, 2'b10);
        end
        chk("tc_cfg_hold", cfg_err, 1'b1);

        // Current-sign filter
        i_pos_raw = 1'b1; nclk(2); i_pos_raw = 1'b0;
        nclk(6);
        chk("sg_short_pulse", current_sign, 1'b0);
        i_pos_raw = 1'b1; nclk(3); i_pos_raw = 1'b0;
        nclk(1);
        chk("sg_before_third", current_sign, 1'b0);
        nclk(1);
        chk("sg_third", current_sign, 1'b1);
        i_pos_raw = 1'b1; i_neg_raw = 1'b1; nclk(8);
        i_pos_raw = 1'b0; i_neg_raw = 1'b0; nclk(4);
        chk("sg_both_hold", current_sign, 1'b1);
        i_neg_raw = 1'b1; nclk(3); i_neg_raw = 1'b0;
        nclk(4);
        chk("sg_neg", current_sign, 1'b0);
        i_pos_raw = 1'b1; nclk(2); i_pos_raw = 1'b0; nclk(1);
        i_pos_raw = 1'b1; nclk(2); i_pos_raw = 1'b0;
        nclk(6);
        chk("sg_gap_reset", current_sign, 1'b0);

        // Mid-period fault at cnt=40
        en = 1'b0;
        nclk(1);
        period = 100; duty_a = 30; duty_b = 50; en = 1'b1;
        nclk(41);
        fault_in = 1'b1;
        nclk(1);
        fault_in = 1'b0;
        chk("flt_short_0", short_out, 1'b0);
        nclk(1);
        chk("flt_short_1", short_out, 1'b0);
        chk("flt_start_1", start, 1'b1);
        chk("flt_load_1", desired_load, 2'b10);
        nclk(1);
        chk("flt_short", short_out, 1'b1);
        chk("flt_start", start, 1'b0);
        chk("flt_load", desired_load, 2'b00);
        en = 1'b0; nclk(3); en = 1'b1;
        nclk(120);
        chk("flt_sticky_short", short_out, 1'b1);
        chk("flt_sticky_start", start, 1'b0);
        chk("flt_sticky_load", desired_load, 2'b00);

        // Asynchronous reset clears the latch without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("arst_short", short_out, 1'b0);
        chk("arst_cfg", cfg_err, 1'b0);
        chk("arst_start", start, 1'b0);
        chk("arst_load", desired_load, 2'b00);
        nclk(2);
        rst = 1'b0;
        nclk(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phase_select_sequencer.md
Name: phase_select_sequencer

Overview:
- Upstream stage of the 3-phase bidirectional-switch commutation FSM. Generates that FSM's DesiredLoad, CurrentSign, start and Short inputs.
- Converts per-period duty counts for input phases A/B/C into a time-sliced load-phase selection, using symmetric (forward/reverse) sequencing.
- Filters the raw output-current comparators into a stable sign.
- Synchronises and latches external faults.

Parameters:
- CNT_W, 12, width of period/duty counters.
- MIN_DWELL, 4, minimum nonzero segment length in clk cycles. Covers the commutation FSM's 4-step walk.
- SIGN_FILT, 3, consecutive agreeing samples required to change current_sign.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; level.
- period  in  CNT_W  switching period in cycles; sampled at period boundary.
- duty_a  in  CNT_W  phase-A dwell; sampled at period boundary.
- duty_b  in  CNT_W  phase-B dwell; sampled at period boundary.
- i_pos_raw  in  1  async comparator, output current > +band.
- i_neg_raw  in  1  async comparator, output current < -band.
- fault_in  in  1  async desat/overcurrent fault.
- desired_load  out  2  01=A, 10=B, 11=C, 00=none.
- current_sign  out  1  1=positive, 0=negative.
- start  out  1  commutation FSM enable.
- short_out  out  1  sticky fault to the commutation FSM Short input.
- period_tick  out  1  one-cycle pulse at each shadow load.
- cfg_err  out  1  sticky config error; cleared at the next valid load.

Behaviour:
- Reset: all outputs 0, counter 0, shadows 0, direction forward, filter counters 0.
- Counter and shadow load:
  - cnt runs 0..P-1, where P is the shadow period. The shadow load occurs when cnt wraps to 0, or on the first cycle with en=1 from idle.
  - On load: P=period, a=duty_a, b=duty_b. If a>P, a=P. If a+b>P, b=P-a. Both clamps set cfg_err. c=P-a-b.
  - period_tick pulses on the load cycle.
- Dwell trim:
  - Any nonzero duty <MIN_DWELL becomes 0.
  - Its cycles are added to the largest remaining duty; ties resolve A>B>C.
- Invalid period: if P<MIN_DWELL, then cfg_err=1, start=0, desired_load=00, and the counter holds 0. Re-evaluated each cycle with en=1.
- Direction: toggles at every load.
  - Forward order is A,B,C; reverse order is C,B,A.
  - Segment boundaries are the cumulative sums of duties in the current order.
  - Zero-length segments are skipped.
  - Consecutive periods therefore share an edge segment, giving no commutation at the boundary.
- Output timing:
  - desired_load is registered: the segment for cnt=k appears on the output one cycle later.
  - start goes to 1 one cycle after the first load with a valid P. It drops to 0 one cycle after en falls or short_out rises.
  - With start=0, desired_load=00.
- Sign filter:
  - i_pos_raw and i_neg_raw each pass through a 2-FF synchroniser.
  - Sample pos=1,neg=0 counts toward sign=1; pos=0,neg=1 counts toward sign=0.
  - neither=1 (zero band) or both=1 (illegal) reset the run counter and hold the sign.
  - current_sign changes after SIGN_FILT consecutive agreeing samples, counted after the synchroniser.
- Fault:
  - fault_in passes through a 2-FF synchroniser.
  - On the first high sample: short_out=1, sticky until rst. Also start=0 and desired_load=00 in the same registered cycle.
  - en toggling does not clear it.
- en falling mid-period:
  - Counter resets to 0 and direction resets to forward; outputs go idle next cycle.
  - Shadows are retained but reloaded on re-enable.
- rst mid-operation clears everything asynchronously, including short_out.

Decomposition:
- Shared package holds:
  - Load codes LOAD_A=01, LOAD_B=10, LOAD_C=11, LOAD_NUL=00, identical to the commutation FSM encoding.
  - Direction enum FWD/REV.
  - The sync depth constant 2.
- One sub-module: current_sign_filter, containing the synchroniser, run counter and sign register.
- Period/segment logic and fault latch stay in the top level.

Test Plan:
- Symmetric sequencing: en=1, period=100, duty_a=30, duty_b=50. Period 1 gives A×30, B×50, C×20. Period 2 gives C×20, B×50, A×30. period_tick every 100 cycles; C is held 40 cycles across the boundary.
- Trim and clamp: period=100, duty_a=2, duty_b=120. Result a=0, b=100, c=0, cfg_err=1, desired_load=10 for the whole period.
- Current-sign filtering: i_pos_raw pulses high for 2 cycles then drops, so current_sign stays 0. Held high for 3 synchronised cycles, current_sign=1. Both comparators high leaves the sign unchanged.
- Mid-period fault: fault_in pulse of 1 cycle at cnt=40. short_out=1 and start=0 within 3 cycles; desired_load=00; state persists with en toggled until rst.
- Invalid period: period=3 gives cfg_err=1, start=0, desired_load=00. Then period=50, duty_a=25, duty_b=25 gives start=1 after the load, and cfg_err clears.
- en drop at cnt=60 of a reverse period: idle next cycle. Re-enable restarts forward from phase A with fresh duties.
